// File: rtl/mul_step_sequencer_if.sv
// rtl/mul_step_sequencer_if.sv - request/step handshake bundle between the multiplier front end and the step sequencer
interface mul_step_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             stall;
  logic             abort;
  logic             done_ack;
  logic             busy;
  logic             step_en;
  logic [CNT_W-1:0] step_idx;
  logic             first_step;
  logic             last_step;
  logic             done;

  modport master (
    output start, stall, abort, done_ack,
    input  busy, step_en, step_idx, first_step, last_step, done
  );

  modport slave (
    input  start, stall, abort, done_ack,
    output busy, step_en, step_idx, first_step, last_step, done
  );
endinterface

// File: rtl/mul_step_sequencer.sv
// rtl/mul_step_sequencer.sv - step-enable sequencer for the iterative radix-16 Booth multiplier
module mul_step_sequencer #(
  parameter int NUM_STEPS = 9,
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mul_step_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_STEPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;

  // Iteration advances only when the datapath is not back-pressuring.
  logic step_fire;
  assign step_fire = busy_q && !bus.stall;

  // Next index while stepping; only used below LAST_IDX so it never wraps.
  logic [CNT_W-1:0] idx_d;
  assign idx_d = idx_q + CNT_W'(1);

  // Control FSM: state, step index and the registered busy/done flags move together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // abort in IDLE suppresses a coincident start.
          if (bus.start && !bus.abort) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (step_fire) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_d;
            end
          end
        end

        ST_DONE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else if (!HOLD_DONE || bus.done_ack) begin
            // Leaving DONE: a coincident start chains straight into the next operation.
            done_q <= 1'b0;
            if (bus.start) begin
              state_q <= ST_RUN;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_idx   = idx_q;
  assign bus.step_en    = step_fire;
  assign bus.first_step = step_fire && (idx_q == '0);
  assign bus.last_step  = step_fire && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_mul_step_sequencer.sv
// tb/tb_mul_step_sequencer.sv - self-checking bench for mul_step_sequencer (held and pulsed done variants)
module tb_mul_step_sequencer;

  localparam int N0 = 9;
  localparam int N1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stall, abort, ack;

  mul_step_sequencer_if #(.CNT_W($clog2(N0))) if0 ();
  mul_step_sequencer_if #(.CNT_W($clog2(N1))) if1 ();

  assign if0.start = start;
  assign if0.stall = stall;
  assign if0.abort = abort;
  assign if0.done_ack = ack;
  assign if1.start = start;
  assign if1.stall = stall;
  assign if1.abort = abort;
  assign if1.done_ack = ack;

  mul_step_sequencer #(.NUM_STEPS(N0), .HOLD_DONE(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(if0)
  );
  mul_step_sequencer #(.NUM_STEPS(N1), .HOLD_DONE(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(if1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: remaining iterations of the current operation plus a pending-result flag.
  int n_cfg[2]    = '{N0, N1};
  bit hold_cfg[2] = '{1'b1, 1'b0};
  int left[2]     = '{0, 0};
  bit dn[2]       = '{1'b0, 1'b0};

  task automatic check(string tag, integer obs, integer exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int nl[2];
    bit nd[2];
    integer ob, oe, oi, of, ol, od;
    integer eb, ee, ei, ef, el, ed;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (chk_en) begin
        if (d == 0) begin
          ob = if0.busy; oe = if0.step_en; oi = if0.step_idx;
          of = if0.first_step; ol = if0.last_step; od = if0.done;
        end else begin
          ob = if1.busy; oe = if1.step_en; oi = if1.step_idx;
          of = if1.first_step; ol = if1.last_step; od = if1.done;
        end
        eb = (left[d] > 0) ? 1 : 0;
        ee = (left[d] > 0 && !stall) ? 1 : 0;
        ei = (left[d] > 0) ? n_cfg[d] - left[d] : 0;
        ef = (ee == 1 && ei == 0) ? 1 : 0;
        el = (ee == 1 && left[d] == 1) ? 1 : 0;
        ed = dn[d] ? 1 : 0;
        check($sformatf("d%0d_busy@%0d", d, cyc), ob, eb);
        check($sformatf("d%0d_step_en@%0d", d, cyc), oe, ee);
        check($sformatf("d%0d_step_idx@%0d", d, cyc), oi, ei);
        check($sformatf("d%0d_first@%0d", d, cyc), of, ef);
        check($sformatf("d%0d_last@%0d", d, cyc), ol, el);
        check($sformatf("d%0d_done@%0d", d, cyc), od, ed);
      end
      nl[d] = left[d];
      nd[d] = dn[d];
      if (rst) begin
        nl[d] = 0;
        nd[d] = 1'b0;
      end else if (left[d] > 0) begin
        if (abort) nl[d] = 0;
        else if (!stall) begin
          nl[d] = left[d] - 1;
          if (nl[d] == 0) nd[d] = 1'b1;
        end
      end else if (dn[d]) begin
        if (abort) nd[d] = 1'b0;
        else if (!hold_cfg[d] || ack) begin
          nd[d] = 1'b0;
          if (start) nl[d] = n_cfg[d];
        end
      end else if (start && !abort) begin
        nl[d] = n_cfg[d];
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      left[d] = nl[d];
      dn[d]   = nd[d];
    end
    cyc++;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic quiet();
    start = 0; stall = 0; abort = 0; ack = 0; rst = 0;
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; abort = 0; ack = 0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    quiet();
    run(10);

    // Basic: start pulse, ack after done has been held a few cycles.
    start = 1; step();
    start = 0; run(11);
    ack = 1; step();
    ack = 0; run(3);

    // Stall for three cycles mid-operation.
    start = 1; step();
    start = 0; run(2);
    stall = 1; run(3);
    stall = 0; run(9);
    ack = 1; step();
    ack = 0; run(2);

    // Abort while busy, then a fresh start.
    start = 1; step();
    start = 0; run(4);
    abort = 1; step();
    abort = 0; step();
    start = 1; step();
    start = 0; run(12);

    // Priority in DONE: abort wins over start and done_ack.
    abort = 1; start = 1; ack = 1; step();
    quiet(); run(3);

    // Start during RUN is ignored; step count is unchanged.
    start = 1; step();
    start = 0; run(3);
    start = 1; run(3);
    start = 0; run(5);
    ack = 1; step();
    ack = 0; step();

    // Abort in IDLE suppresses start.
    start = 1; abort = 1; step();
    quiet(); run(2);

    // Back-to-back: start held high, and start with done_ack chains the held-done unit.
    start = 1; run(12);
    ack = 1; run(12);
    quiet(); run(3);

    // Randomized traffic including rare resets.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 99) < 35);
      stall = ($urandom_range(0, 99) < 20);
      abort = ($urandom_range(0, 99) < 4);
      ack   = ($urandom_range(0, 99) < 30);
      rst   = ($urandom_range(0, 199) < 2);
      step();
    end
    quiet(); run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
